// File: rtl/deconvolve.sv
// Sequential polynomial long division: recovers b from y = a (*) b using one
// MAC and one restoring divider, then re-checks the tail of y as residuals.
module deconvolve #(
  parameter int NA = 4,
  parameter int NB = 4,
  parameter int W  = 32,
  localparam int NY = NA + NB - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a [NA-1:0],
  input  logic [W-1:0] y [NY-1:0],
  output logic [W-1:0] b [NB-1:0],
  output logic         busy,
  output logic         done,
  output logic         exact,
  output logic         err
);

  localparam int KW = $clog2(NY + 1);
  localparam int AW = $clog2(NA);
  localparam int BW = $clog2(NB);
  localparam int YW = $clog2(NY);
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_MAC      = 3'd2;
  localparam logic [2:0] S_DIV      = 3'd3;
  localparam logic [2:0] S_CHK_LOAD = 3'd4;
  localparam logic [2:0] S_CHK_MAC  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [KW-1:0] NA_M1 = KW'(NA - 1);
  localparam logic [KW-1:0] NB_K  = KW'(NB);
  localparam logic [KW-1:0] NY_K  = KW'(NY);

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d, j_q, j_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d, rem_q, rem_d, dvd_q, dvd_d;
  logic [W-1:0]  b_q [NB-1:0];
  logic [W-1:0]  b_d [NB-1:0];
  logic          exact_q, exact_d, err_q, err_d;

  logic [W-1:0]  a0, dvs, acc_abs, prod, div_rin, div_din, rem_sub, rem_n, dvd_n, quo_s;
  logic [BW-1:0] kj;
  logic [KW-1:0] jmax;
  logic [W:0]    trial;
  logic          ge;

  always_comb begin
    a0      = a[0];
    dvs     = a0[W-1] ? -a0 : a0;
    acc_abs = acc_q[W-1] ? -acc_q : acc_q;
    kj      = k_q[BW-1:0] - j_q[BW-1:0];
    prod    = a[j_q[AW-1:0]] * b_q[kj];
    jmax    = (k_q < NA_M1) ? k_q : NA_M1;
    // First divide iteration takes the dividend straight from acc, so the
    // divider needs no separate load cycle.
    div_rin = (cnt_q == '0) ? '0 : rem_q;
    div_din = (cnt_q == '0) ? acc_abs : dvd_q;
    trial   = {div_rin, div_din[W-1]};
    ge      = trial >= {1'b0, dvs};
    rem_sub = trial[W-1:0] - dvs;
    rem_n   = ge ? rem_sub : trial[W-1:0];
    dvd_n   = {div_din[W-2:0], ge};
    quo_s   = (acc_q[W-1] ^ a0[W-1]) ? -dvd_q : dvd_q;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    exact_d = exact_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        for (int i = 0; i < NB; i++) b_d[i] = '0;
        k_d = '0;
        if (a0 == '0) begin
          err_d   = 1'b1;
          exact_d = 1'b0;
          state_d = S_DONE;
        end else begin
          err_d   = 1'b0;
          exact_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = y[k_q[YW-1:0]];
        j_d     = KW'(1);
        cnt_d   = '0;
        state_d = (k_q == '0) ? S_DIV : S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q - prod;
        if (j_q == jmax) state_d = S_DIV;
        else             j_d = j_q + KW'(1);
      end
      S_DIV: begin
        if (cnt_q != CW'(W)) begin
          rem_d = rem_n;
          dvd_d = dvd_n;
          cnt_d = cnt_q + CW'(1);
        end else begin
          b_d[k_q[BW-1:0]] = quo_s;
          if (rem_q != '0) exact_d = 1'b0;
          k_d     = k_q + KW'(1);
          state_d = ((k_q + KW'(1)) < NB_K) ? S_LOAD : S_CHK_LOAD;
        end
      end
      S_CHK_LOAD: begin
        // acc still holds the residual of the previous tail sample here.
        if (k_q > NB_K && acc_q != '0) exact_d = 1'b0;
        if (k_q == NY_K) begin
          state_d = S_DONE;
        end else begin
          acc_d   = y[k_q[YW-1:0]];
          j_d     = k_q - NB_K + KW'(1);
          state_d = S_CHK_MAC;
        end
      end
      S_CHK_MAC: begin
        acc_d = acc_q - prod;
        if (j_q == NA_M1) begin
          k_d     = k_q + KW'(1);
          state_d = S_CHK_LOAD;
        end else begin
          j_d = j_q + KW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      for (int i = 0; i < NB; i++) b_q[i] <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      exact_q <= exact_d;
      err_q   <= err_d;
    end
  end

  assign b     = b_q;
  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done  = (state_q == S_DONE);
  assign exact = exact_q;
  assign err   = err_q;

endmodule

// File: tb/tb_deconvolve.sv
// Bench for deconvolve: directed cases plus randomized vectors checked against
// an integer long-division reference model.
module tb_deconvolve;

  localparam int NA = 4;
  localparam int NB = 4;
  localparam int W  = 32;
  localparam int NY = NA + NB - 1;
  localparam int LAT = 152;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a_drv [NA-1:0];
  logic [W-1:0] y_drv [NY-1:0];
  logic [W-1:0] b_o   [NB-1:0];
  logic         busy, done, exact, err;

  int checks = 0;
  int failures = 0;
  int eb [NB];
  bit eex, eerr;

  always #5 clk = ~clk;

  deconvolve #(.NA(NA), .NB(NB), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a_drv), .y(y_drv),
    .b(b_o), .busy(busy), .done(done), .exact(exact), .err(err)
  );

  // Reference: b[k] = (y[k] - sum a[j]*b[k-j]) / a[0] in wrapping int arithmetic.
  function automatic void model();
    int av [NA];
    int yv [NY];
    int acc, r;
    int imin;
    imin = int'(32'h8000_0000);
    for (int i = 0; i < NA; i++) av[i] = int'(a_drv[i]);
    for (int i = 0; i < NY; i++) yv[i] = int'(y_drv[i]);
    for (int i = 0; i < NB; i++) eb[i] = 0;
    eex = 1'b1; eerr = 1'b0;
    if (av[0] == 0) begin
      eerr = 1'b1; eex = 1'b0;
      return;
    end
    for (int k = 0; k < NB; k++) begin
      acc = yv[k];
      for (int j = 1; j <= k && j < NA; j++) acc -= av[j] * eb[k-j];
      if (acc == imin && av[0] == -1) begin
        eb[k] = imin; r = 0;
      end else begin
        eb[k] = acc / av[0]; r = acc % av[0];
      end
      if (r != 0) eex = 1'b0;
    end
    for (int k = NB; k < NY; k++) begin
      acc = yv[k];
      for (int j = k - NB + 1; j < NA; j++) acc -= av[j] * eb[k-j];
      if (acc != 0) eex = 1'b0;
    end
  endfunction

  task automatic set_a(input int a0, input int a1, input int a2, input int a3);
    a_drv[0] = a0; a_drv[1] = a1; a_drv[2] = a2; a_drv[3] = a3;
  endtask

  task automatic set_y(input int y0, input int y1, input int y2, input int y3,
                       input int y4, input int y5, input int y6);
    y_drv[0] = y0; y_drv[1] = y1; y_drv[2] = y2; y_drv[3] = y3;
    y_drv[4] = y4; y_drv[5] = y5; y_drv[6] = y6;
  endtask

  // Single operation from a start pulse through the done pulse and one hold cycle.
  task automatic run_case(input string name);
    int lat, explat;
    bit busy_seen;
    model();
    explat = eerr ? 0 : LAT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_seen = busy;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
      busy_seen |= busy;
    end
    checks++;
    if (lat != explat) begin
      failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, explat);
    end
    checks++;
    if (busy_seen != !eerr) begin
      failures++; $display("FAIL %s busy_seen got=%0b exp=%0b", name, busy_seen, !eerr);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (b_o[i] !== eb[i]) begin
        failures++; $display("FAIL %s b[%0d] got=%0d exp=%0d", name, i, $signed(b_o[i]), eb[i]);
      end
    end
    checks++;
    if (exact !== eex || err !== eerr) begin
      failures++;
      $display("FAIL %s exact/err got=%0b/%0b exp=%0b/%0b", name, exact, err, eex, eerr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || b_o[NB-1] !== eb[NB-1] || exact !== eex) begin
      failures++;
      $display("FAIL %s hold done=%0b busy=%0b b3=%0d exact=%0b exp b3=%0d exact=%0b",
               name, done, busy, $signed(b_o[NB-1]), exact, eb[NB-1], eex);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    set_a(0, 0, 0, 0); set_y(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, exact, err} !== 4'b0000) begin
      failures++; $display("FAIL reset flags got=%b exp=0000", {busy, done, exact, err});
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (b_o[i] !== '0) begin
        failures++; $display("FAIL reset b[%0d] got=%0d exp=0", i, b_o[i]);
      end
    end
  endtask

  task automatic test_t1();
    set_a(1, 2, 3, 4); set_y(5, 16, 34, 60, 61, 52, 32);
    run_case("t1");
    checks++;
    if (b_o[0] !== 5 || b_o[1] !== 6 || b_o[2] !== 7 || b_o[3] !== 8) begin
      failures++;
      $display("FAIL t1_const b got=%0d,%0d,%0d,%0d exp=5,6,7,8", b_o[0], b_o[1], b_o[2], b_o[3]);
    end
  endtask

  task automatic test_t2_t3();
    set_a(-2, 1, 0, 1); set_y(-6, 5, -1, -1, 1, 0, 2);
    run_case("t2");
    set_y(-6, 5, -1, -1, 1, 0, 3);
    run_case("t3_tail");
    set_a(2, 0, 0, 0); set_y(7, 0, 0, 0, 0, 0, 0);
    run_case("t3_rem");
    set_y(-7, 0, 0, 0, 0, 0, 0);
    run_case("t3_trunc");
    checks++;
    if (b_o[0] !== -3) begin
      failures++; $display("FAIL t3_trunc_const b0 got=%0d exp=-3", $signed(b_o[0]));
    end
  endtask

  task automatic test_div0();
    set_a(0, 3, 2, 1); set_y(1, 2, 3, 4, 5, 6, 7);
    run_case("div0");
  endtask

  task automatic test_overflow();
    set_a(-1, 0, 0, 0); set_y(int'(32'h8000_0000), 0, 0, 0, 0, 0, 0);
    run_case("overflow");
  endtask

  task automatic test_start_ignored();
    int lat;
    set_a(1, 2, 3, 4); set_y(5, 16, 34, 60, 61, 52, 32);
    model();
    start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      start = (lat == 19);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != LAT) begin
      failures++; $display("FAIL start_ignored latency got=%0d exp=%0d", lat, LAT);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (b_o[i] !== eb[i]) begin
        failures++; $display("FAIL start_ignored b[%0d] got=%0d exp=%0d", i, $signed(b_o[i]), eb[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    set_a(-2, 1, 0, 1); set_y(-6, 5, -1, -1, 1, 0, 2);
    model();
    start = 1'b1;
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      lat = 0;
      while (done !== 1'b1 && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != LAT) begin
        failures++; $display("FAIL b2b run%0d latency got=%0d exp=%0d", run, lat, LAT);
      end
      checks++;
      if (b_o[0] !== eb[0] || b_o[3] !== eb[3] || exact !== eex) begin
        failures++;
        $display("FAIL b2b run%0d b0=%0d b3=%0d exact=%0b exp %0d %0d %0b",
                 run, $signed(b_o[0]), $signed(b_o[3]), exact, eb[0], eb[3], eex);
      end
      if (run == 0) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          failures++; $display("FAIL b2b idle busy=%0b done=%0b exp=0/0", busy, done);
        end
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b stop busy got=%0b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    set_a(1, 2, 3, 4); set_y(5, 16, 34, 60, 61, 52, 32);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, exact, err} !== 4'b0000) begin
      failures++; $display("FAIL mid_reset flags got=%b exp=0000", {busy, done, exact, err});
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (b_o[i] !== '0) begin
        failures++; $display("FAIL mid_reset b[%0d] got=%0d exp=0", i, $signed(b_o[i]));
      end
    end
    @(negedge clk);
    set_a(-2, 1, 0, 1); set_y(-6, 5, -1, -1, 1, 0, 2);
    run_case("after_reset_t2");
  endtask

  task automatic test_random();
    int av [NA];
    int bv [NB];
    int yk;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NA; i++) begin
        if (it % 4 == 3) av[i] = int'($urandom);
        else             av[i] = int'($urandom_range(0, 18)) - 9;
      end
      if (av[0] == 0) av[0] = 3;
      for (int i = 0; i < NB; i++) begin
        if (it % 4 == 3) bv[i] = int'($urandom);
        else             bv[i] = int'($urandom_range(0, 400)) - 200;
      end
      for (int i = 0; i < NA; i++) a_drv[i] = av[i];
      for (int k = 0; k < NY; k++) begin
        yk = 0;
        for (int j = 0; j < NA; j++)
          if (k - j >= 0 && k - j < NB) yk += av[j] * bv[k-j];
        y_drv[k] = yk;
      end
      if (it % 3 == 1) y_drv[$urandom_range(0, NY-1)] += W'($urandom_range(1, 5));
      run_case($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_t1();
    test_t2_t3();
    test_div0();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
